mem_align_bridge: RTL and testbench
===================================

Name: mem_align_bridge

Overview:
- Sits between the multicycle control/datapath memory port and physical memory.
- Accepts one load or store at a time and checks alignment.
- Generates the byte enables and the shifted store data for physical memory.
- Runs a multi-cycle read/write handshake with a wait-state timeout, then returns sign- or zero-extended load data with a single-cycle response.

Parameters:
- MAX_WAIT, 64: max cycles pmem_read/pmem_write stays asserted without pmem_resp before the bridge aborts with an error (range 1..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_address  in  32  byte address from datapath (MAR)
- mem_read  in  1  load request; held high until mem_resp
- mem_write  in  1  store request; held high until mem_resp
- mem_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_wdata  in  32  unshifted store value (rs2)
- mem_rdata  out  32  aligned, extended load result
- mem_resp  out  1  one-cycle completion pulse
- mem_err  out  1  qualifies mem_resp: access faulted
- pmem_address  out  32  word-aligned address, {mem_address[31:2],2'b00}
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_wdata  out  32  lane-replicated store data
- pmem_byte_enable  out  4  active lanes
- pmem_rdata  in  32  physical read word, valid with pmem_resp
- pmem_resp  in  1  physical completion, one or more cycles

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wait counter=0.
  - All outputs 0: mem_rdata, mem_resp, mem_err, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable, pmem_address.
  - Reset mid-transaction drops pmem strobes immediately; no response is issued.
- States: IDLE, REQ, DONE, ERR.
- IDLE, with mem_read or mem_write high: latch address, funct3, wdata and direction; clear counter.
  - Go to ERR if any of these hold:
    - both mem_read and mem_write are high;
    - funct3 is invalid for the direction (loads: 011/110/111; stores: anything other than 000/001/010);
    - misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Otherwise go to REQ.
- REQ:
  - pmem_read or pmem_write high; pmem_address, pmem_wdata and pmem_byte_enable are registered and stable for the whole state.
  - pmem_resp=1: capture pmem_rdata, go to DONE.
  - Otherwise increment counter; counter==MAX_WAIT-1 with no pmem_resp → deassert strobe, go to ERR.
- DONE: mem_resp=1, mem_err=0 for exactly one cycle; then IDLE.
- ERR: mem_resp=1, mem_err=1 for exactly one cycle; mem_rdata unchanged; no pmem strobe in this state; then IDLE.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Store data:
  - B: wdata[7:0] replicated ×4.
  - H: wdata[15:0] replicated ×2.
  - W: wdata unchanged.
- Load extraction from the captured word:
  - Byte lane selected by addr[1:0]; halfword lane selected by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - mem_rdata is updated on entry to DONE and held until the next successful load.
- Latency: request sampled at cycle 0 → strobe at cycle 1; pmem_resp at cycle k≥1 → mem_resp at cycle k+1. Minimum 2 cycles.
- Back-to-back requests:
  - The requester drops its request in the cycle after mem_resp. A request present in IDLE starts a new transaction without a bubble.
  - Request inputs are ignored outside IDLE. Request deassertion during REQ does not abort; the transaction completes.
- pmem_resp outside REQ is ignored.

Test Plan:
- LB at 0x1003, pmem_rdata=0x80FF_1234 after 3 waits → pmem_byte_enable=1000, mem_rdata=0xFFFF_FF80, mem_resp at cycle 5, mem_err=0; LBU same → 0x0000_0080.
- SH at 0x2002, mem_wdata=0xDEAD_BEEF → pmem_write=1, pmem_address=0x2000, pmem_byte_enable=1100, pmem_wdata=0xBEEF_BEEF, one mem_resp pulse.
- LW at 0x3001 → no pmem_read ever asserted, mem_resp=1 and mem_err=1 at cycle 1 only; LH at 0x3003 likewise.
- Read with pmem_resp never asserted, MAX_WAIT=4 → pmem_read high exactly 4 cycles, then mem_resp=mem_err=1; subsequent SW at 0x10 completes normally.
- LW at 0x40 with pmem_resp tied high → mem_resp at cycle 2, mem_rdata=pmem_rdata; second LW issued immediately after completes with no bubble.
- rst_n low while in REQ → pmem_read falls in the same cycle without waiting for a clock edge, no mem_resp; after release the state is IDLE and all outputs are 0.

Source files
------------

// File: rtl/mem_align_bridge_if.sv
// mem_align_bridge_if
//   Groups the datapath-side memory port and the physical-memory port of the
//   alignment bridge into one bundle.
//   Modports:
//     slave  - the bridge's view: it receives requests from the datapath
//              and pmem_rdata/pmem_resp from memory, and drives the load
//              result, the response and the physical strobes/address/data.
//     master - the environment's view (datapath + physical memory): the
//              directions are the reverse of slave.
interface mem_align_bridge_if;
  // datapath side
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;
  // physical memory side
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_funct3, mem_wdata,
    output mem_rdata, mem_resp, mem_err,
    output pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_funct3, mem_wdata,
    input  mem_rdata, mem_resp, mem_err,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_align_bridge.sv
// mem_align_bridge
//   Bridge between the multicycle datapath memory port and physical memory.
//   Takes one load or store at a time, rejects bad or misaligned accesses,
//   builds byte enables and lane-replicated store data, runs the physical
//   read/write handshake with a wait-state timeout, and returns the
//   sign/zero-extended load result with a one-cycle mem_resp pulse.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - mem_align_bridge_if.slave (datapath request/response and
//             physical memory strobes/data)
//   Parameter:
//     MAX_WAIT - cycles a physical strobe may stay up without pmem_resp
//                before the access is aborted with mem_err (1..255)
module mem_align_bridge #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_align_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic        write_reg;
  logic [31:0] pmem_wdata_reg;
  logic [3:0]  byte_enable_reg;
  logic [31:0] rdata_reg;

  logic        req;
  logic        bad_funct;
  logic        misaligned;
  logic        req_bad;
  logic        capture;
  logic [3:0]  byte_enable;
  logic [3:0][7:0] store_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;

  // ---------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------
  assign req = bus.mem_read || bus.mem_write;

  // Stores only have B/H/W; loads additionally have BU/HU.
  always_comb begin
    bad_funct = 1'b0;
    if (bus.mem_write) begin
      bad_funct = !(bus.mem_funct3 == 3'b000 || bus.mem_funct3 == 3'b001 ||
                    bus.mem_funct3 == 3'b010);
    end else begin
      bad_funct = (bus.mem_funct3 == 3'b011 || bus.mem_funct3 == 3'b110 ||
                   bus.mem_funct3 == 3'b111);
    end
  end

  // funct3[1:0] == 01 covers both H and HU.
  assign misaligned = (bus.mem_funct3[1:0] == 2'b01 && bus.mem_address[0]) ||
                      (bus.mem_funct3 == 3'b010 && bus.mem_address[1:0] != 2'b00);

  assign req_bad = (bus.mem_read && bus.mem_write) || bad_funct || misaligned;

  always_comb begin
    byte_enable = 4'b1111;
    case (bus.mem_funct3[1:0])
      2'b00:   byte_enable = 4'b0001 << bus.mem_address[1:0];
      2'b01:   byte_enable = 4'b0011 << {bus.mem_address[1], 1'b0};
      default: byte_enable = 4'b1111;
    endcase
  end

  // Replicate the store value across lanes so memory picks whichever lane
  // the byte enables select.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_lane[gi] = (bus.mem_funct3[1:0] == 2'b00) ? bus.mem_wdata[7:0] :
                            (bus.mem_funct3[1:0] == 2'b01) ? bus.mem_wdata[(gi % 2) * 8 +: 8] :
                                                              bus.mem_wdata[gi * 8 +: 8];
  end

  // ---------------------------------------------------------------------
  // Load extraction from the returning physical word
  // ---------------------------------------------------------------------
  always_comb begin
    ld_byte    = bus.pmem_rdata[{addr_reg[1:0], 3'b000} +: 8];
    ld_half    = addr_reg[1] ? bus.pmem_rdata[31:16] : bus.pmem_rdata[15:0];
    load_value = bus.pmem_rdata;
    case (funct3_reg)
      3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_value = {24'b0, ld_byte};
      3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_value = {16'b0, ld_half};
      default: load_value = bus.pmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          wait_cnt_next = 8'd0;
          state_next    = req_bad ? ERR : REQ;
        end
      end
      REQ: begin
        if (bus.pmem_resp) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (wait_cnt_reg == 8'(MAX_WAIT - 1)) begin
          // Strobe has been up MAX_WAIT cycles with no answer.
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= 8'd0;
      addr_reg        <= 32'd0;
      funct3_reg      <= 3'd0;
      write_reg       <= 1'b0;
      pmem_wdata_reg  <= 32'd0;
      byte_enable_reg <= 4'd0;
      rdata_reg       <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == IDLE && req) begin
        addr_reg        <= bus.mem_address;
        funct3_reg      <= bus.mem_funct3;
        write_reg       <= bus.mem_write;
        pmem_wdata_reg  <= store_lane;
        byte_enable_reg <= byte_enable;
      end
      // Stores also complete through DONE but must leave the load result alone.
      if (capture && !write_reg) begin
        rdata_reg <= load_value;
      end
    end
  end

  // Strobes and the response decode straight from the state register, so an
  // asynchronous reset drops them immediately and ERR never carries a strobe.
  assign bus.pmem_read        = (state_reg == REQ) && !write_reg;
  assign bus.pmem_write       = (state_reg == REQ) && write_reg;
  assign bus.pmem_address     = {addr_reg[31:2], 2'b00};
  assign bus.pmem_wdata       = pmem_wdata_reg;
  assign bus.pmem_byte_enable = byte_enable_reg;
  assign bus.mem_rdata        = rdata_reg;
  assign bus.mem_resp         = (state_reg == DONE) || (state_reg == ERR);
  assign bus.mem_err          = (state_reg == ERR);

endmodule

// File: tb/tb_mem_align_bridge.sv
// tb_mem_align_bridge
//   Directed bench for mem_align_bridge (MAX_WAIT = 4). Expected responses are
//   pushed onto a scoreboard when a request is driven and popped when the DUT
//   raises mem_resp. Outputs are sampled on the falling clock edge.
module tb_mem_align_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_align_bridge_if bus ();

  mem_align_bridge #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Per-transaction observations
  int          resp_cyc;
  int          strobe_cyc;
  int          first_strobe;
  int          unstable;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_rd;
  logic        seen_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request in the cycle after the caller's last falling edge and
  // serve the physical side: pmem_resp rises on strobe cycle waits+1.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int waits, input logic tie, input logic [31:0] prd,
                     input logic exp_err, input logic [31:0] exp_rdata);
    exp_t e;
    logic got;
    @(negedge clk);
    chk("resp_single_pulse", 32'(bus.mem_resp), 32'd0);
    e.err = exp_err;
    e.rdata = exp_rdata;
    sb.push_back(e);
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_funct3  = f3;
    bus.mem_address = addr;
    bus.mem_wdata   = wdata;
    bus.pmem_resp   = tie;
    bus.pmem_rdata  = tie ? prd : 32'h5A5A_5A5A;
    resp_cyc = -1; strobe_cyc = 0; first_strobe = -1; unstable = 0;
    seen_rd = 1'b0; seen_wr = 1'b0;
    got = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        if (strobe_cyc == 0) begin
          first_strobe = cyc;
          seen_addr  = bus.pmem_address;
          seen_wdata = bus.pmem_wdata;
          seen_be    = bus.pmem_byte_enable;
          seen_rd    = bus.pmem_read;
          seen_wr    = bus.pmem_write;
        end else if (seen_addr !== bus.pmem_address || seen_wdata !== bus.pmem_wdata ||
                     seen_be !== bus.pmem_byte_enable) begin
          unstable++;
        end
        strobe_cyc++;
        bus.pmem_resp  = tie || (strobe_cyc > waits);
        bus.pmem_rdata = (tie || strobe_cyc > waits) ? prd : 32'h5A5A_5A5A;
      end else begin
        bus.pmem_resp = tie;
      end
      if (bus.mem_resp) begin
        got = 1'b1;
        resp_cyc = cyc;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("mem_err", 32'(bus.mem_err), 32'(e.err));
          chk("mem_rdata", bus.mem_rdata, e.rdata);
        end
        break;
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    if (!got) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    $display("[TB] txn rd=%0b wr=%0b f3=%b addr=%h -> resp@%0d err=%0b rdata=%h strobes=%0d",
             rd, wr, f3, addr, resp_cyc, bus.mem_err, bus.mem_rdata, strobe_cyc);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
    chk({tag, "_mem_resp"}, 32'(bus.mem_resp), 32'd0);
    chk({tag, "_mem_err"}, 32'(bus.mem_err), 32'd0);
    chk({tag, "_pmem_read"}, 32'(bus.pmem_read), 32'd0);
    chk({tag, "_pmem_write"}, 32'(bus.pmem_write), 32'd0);
    chk({tag, "_pmem_wdata"}, bus.pmem_wdata, 32'd0);
    chk({tag, "_pmem_be"}, 32'(bus.pmem_byte_enable), 32'd0);
    chk({tag, "_pmem_address"}, bus.pmem_address, 32'd0);
  endtask

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_funct3 = 3'b000;
    bus.mem_address = 32'd0; bus.mem_wdata = 32'd0;
    bus.pmem_rdata = 32'd0; bus.pmem_resp = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // LB at 0x1003, 3 wait states: lane 3 = 0x80, sign extended
    txn(1, 0, 3'b000, 32'h0000_1003, 32'd0, 3, 0, 32'h80FF_1234, 0, 32'hFFFF_FF80);
    chk("lb_resp_cycle", 32'(resp_cyc), 32'd5);
    chk("lb_first_strobe", 32'(first_strobe), 32'd1);
    chk("lb_be", 32'(seen_be), 32'b1000);
    chk("lb_address", seen_addr, 32'h0000_1000);
    chk("lb_is_read", 32'(seen_rd), 32'd1);

    // LBU same access: zero extended
    txn(1, 0, 3'b100, 32'h0000_1003, 32'd0, 3, 0, 32'h80FF_1234, 0, 32'h0000_0080);
    chk("lbu_resp_cycle", 32'(resp_cyc), 32'd5);

    // SH at 0x2002: upper half lanes, halfword replicated; mem_rdata untouched
    txn(0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 1, 0, 32'h1111_2222, 0, 32'h0000_0080);
    chk("sh_is_write", 32'(seen_wr), 32'd1);
    chk("sh_not_read", 32'(seen_rd), 32'd0);
    chk("sh_address", seen_addr, 32'h0000_2000);
    chk("sh_be", 32'(seen_be), 32'b1100);
    chk("sh_wdata", seen_wdata, 32'hBEEF_BEEF);
    chk("sh_stable", 32'(unstable), 32'd0);
    chk("sh_resp_cycle", 32'(resp_cyc), 32'd3);

    // Misaligned LW / LH: immediate error, no strobe, mem_rdata held
    txn(1, 0, 3'b010, 32'h0000_3001, 32'd0, 0, 0, 32'h0, 1, 32'h0000_0080);
    chk("lw_mis_resp_cycle", 32'(resp_cyc), 32'd1);
    chk("lw_mis_no_strobe", 32'(strobe_cyc), 32'd0);
    txn(1, 0, 3'b001, 32'h0000_3003, 32'd0, 0, 0, 32'h0, 1, 32'h0000_0080);
    chk("lh_mis_resp_cycle", 32'(resp_cyc), 32'd1);
    chk("lh_mis_no_strobe", 32'(strobe_cyc), 32'd0);

    // Illegal requests: both strobes, store BU encoding, load 011
    txn(1, 1, 3'b010, 32'h0000_0020, 32'd0, 0, 0, 32'h0, 1, 32'h0000_0080);
    chk("rw_both_no_strobe", 32'(strobe_cyc), 32'd0);
    txn(0, 1, 3'b100, 32'h0000_0020, 32'd0, 0, 0, 32'h0, 1, 32'h0000_0080);
    chk("st_bad_f3_no_strobe", 32'(strobe_cyc), 32'd0);
    txn(1, 0, 3'b011, 32'h0000_0020, 32'd0, 0, 0, 32'h0, 1, 32'h0000_0080);
    chk("ld_bad_f3_no_strobe", 32'(strobe_cyc), 32'd0);

    // Timeout: pmem_resp never comes, strobe lasts exactly MAX_WAIT cycles
    txn(1, 0, 3'b010, 32'h0000_0100, 32'd0, 1000, 0, 32'h0, 1, 32'h0000_0080);
    chk("timeout_strobes", 32'(strobe_cyc), 32'd4);
    chk("timeout_resp_cycle", 32'(resp_cyc), 32'd5);

    // SW afterwards completes normally
    txn(0, 1, 3'b010, 32'h0000_0010, 32'h1234_5678, 2, 0, 32'h0, 0, 32'h0000_0080);
    chk("sw_be", 32'(seen_be), 32'b1111);
    chk("sw_wdata", seen_wdata, 32'h1234_5678);
    chk("sw_address", seen_addr, 32'h0000_0010);
    chk("sw_resp_cycle", 32'(resp_cyc), 32'd4);

    // SB at 0x73: lane 3, byte replicated
    txn(0, 1, 3'b000, 32'h0000_0073, 32'h0000_00A5, 0, 0, 32'h0, 0, 32'h0000_0080);
    chk("sb_be", 32'(seen_be), 32'b1000);
    chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);

    // pmem_resp tied high: minimum latency, back-to-back without bubble
    txn(1, 0, 3'b010, 32'h0000_0040, 32'd0, 0, 1, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
    chk("lw_tie_resp_cycle", 32'(resp_cyc), 32'd2);
    txn(1, 0, 3'b010, 32'h0000_0044, 32'd0, 0, 1, 32'h0123_4567, 0, 32'h0123_4567);
    chk("lw2_first_strobe", 32'(first_strobe), 32'd1);
    chk("lw2_resp_cycle", 32'(resp_cyc), 32'd2);

    // Halfword / byte extraction variants
    txn(1, 0, 3'b101, 32'h0000_0052, 32'd0, 1, 0, 32'h9ABC_1234, 0, 32'h0000_9ABC);
    chk("lhu_be", 32'(seen_be), 32'b1100);
    txn(1, 0, 3'b001, 32'h0000_0050, 32'd0, 0, 0, 32'h0000_8001, 0, 32'hFFFF_8001);
    chk("lh_be", 32'(seen_be), 32'b0011);
    txn(1, 0, 3'b000, 32'h0000_0061, 32'd0, 0, 0, 32'h0000_7F00, 0, 32'h0000_007F);
    chk("lb_lane1_be", 32'(seen_be), 32'b0010);

    // Reset in the middle of REQ
    @(negedge clk);
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_funct3 = 3'b010;
    bus.mem_address = 32'h0000_0200; bus.pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_pmem_read", 32'(bus.pmem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    #1;
    chk("rst_async_pmem_read", 32'(bus.pmem_read), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(bus.mem_resp), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");
    $display("[TB] mid-transaction reset released");

    // Bridge is back in IDLE and serves a fresh load
    txn(1, 0, 3'b100, 32'h0000_0302, 32'd0, 1, 0, 32'h00C3_0000, 0, 32'h0000_00C3);
    chk("post_reset_resp_cycle", 32'(resp_cyc), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
